multicycle_ctrl: RTL and testbench

//  Moore FSM sequencing a multicycle MIPS datapath (regfile, sign-extend, 3-bit-op ALU, shared memory).

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/alu_decoder.sv | 26 ++
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   state_t      : the twelve controller states
//   OP_* / FN_*  : opcode and R-type funct encodings of the supported subset
//   ALU_*        : 3-bit ALU operation codes
//   SRCB_*       : ALUSrcB mux selects
//   PCSRC_*      : PC source mux selects
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RD2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder.
//   funct       in  6  instr[5:0]
//   alu_op      out 3  ALU operation for the funct (ALU_ADD when unsupported)
//   funct_valid out 1  funct is one of add/sub/and/or/slt
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       funct_valid
);

    always_comb begin
        alu_op      = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath (R-type, lw, sw, beq,
// addi, j). Outputs are a combinational decode of the registered state,
// qualified by zero / mem_ready / opcode / funct where the state needs them.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   opcode, funct      : fields of the instruction register
//   zero, mem_ready    : ALU zero flag, memory access completes this cycle
//   PCEn .. PCSrc      : datapath enables and mux selects
//   illegal            : one-cycle pulse in DECODE on unsupported instruction
//   state_o            : current state encoding (debug)
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCEn,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic [1:0]         PCSrc,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_t     state, next_state;
    logic [2:0] funct_op;
    logic       funct_valid;
    logic       pc_write;
    logic       branch;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_op      (funct_op),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= FETCH;
        else            state <= next_state;
    end

    assign state_o = STATE_W'(state);

    always_comb begin
        next_state = FETCH;
        pc_write   = 1'b0;
        branch     = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ALUOp      = 3'b000;
        PCSrc      = PCSRC_ALU;
        illegal    = 1'b0;

        case (state)
            FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ALUOp      = ALU_ADD;
                IRWrite    = mem_ready;
                pc_write   = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                ALUSrcB = SRCB_IMM_SH2;
                ALUOp   = ALU_ADD;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_valid) next_state = EXECUTE;
                        else             illegal    = 1'b1;
                    end
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      illegal    = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_ADD;
                // IR still holds the lw/sw that got us here.
                next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD       = 1'b1;
                next_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                next_state = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUOp      = funct_op;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_SUB;
                PCSrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALU_ADD;
                next_state = ADDIWB;
            end
            ADDIWB: RegWrite = 1'b1;
            JUMP: begin
                PCSrc    = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: next_state = FETCH;
        endcase

        PCEn = pc_write | (branch & zero);

        // Reset masks every strobe so an abandoned instruction writes nothing.
        if (!sys_rst_n) begin
            PCEn     = 1'b0;
            IorD     = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegDst   = 1'b0;
            MemtoReg = 1'b0;
            RegWrite = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = SRCB_RD2;
            ALUOp    = ALU_ADD;
            PCSrc    = PCSRC_ALU;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Inputs change on the falling edge,
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_multicycle_ctrl;
    import mips_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCEn, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOp;
    logic       illegal;
    logic [3:0] state_o;

    int total = 0;
    int bad = 0;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCEn      (PCEn),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .MemWrite  (MemWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .PCSrc     (PCSrc),
        .illegal   (illegal),
        .state_o   (state_o)
    );

    always #5 sys_clk = ~sys_clk;

    // Bit layout: PCEn IorD IRWrite MemWrite RegDst MemtoReg RegWrite ALUSrcA
    //             ALUSrcB[1:0] ALUOp[2:0] PCSrc[1:0] illegal
    logic [15:0] ctrl;
    assign ctrl = {PCEn, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                   ALUSrcB, ALUOp, PCSrc, illegal};

    function automatic logic [15:0] cv(input logic pcen, input logic iord, input logic irw,
                                       input logic memw, input logic regdst, input logic m2r,
                                       input logic regw, input logic srca, input logic [1:0] srcb,
                                       input logic [2:0] op, input logic [1:0] pcs, input logic ill);
        return {pcen, iord, irw, memw, regdst, m2r, regw, srca, srcb, op, pcs, ill};
    endfunction

    localparam logic [15:0] V_RST      = cv(0,0,0,0,0,0,0,0,2'b00,3'b010,2'b00,0);
    localparam logic [15:0] V_FETCH    = cv(1,0,1,0,0,0,0,0,2'b01,3'b010,2'b00,0);
    localparam logic [15:0] V_FWAIT    = cv(0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0);
    localparam logic [15:0] V_DECODE   = cv(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0);
    localparam logic [15:0] V_DEC_ILL  = cv(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,1);
    localparam logic [15:0] V_MEMADR   = cv(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0);
    localparam logic [15:0] V_MEMRD    = cv(0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);
    localparam logic [15:0] V_MEMWB    = cv(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0);
    localparam logic [15:0] V_MEMWR    = cv(0,1,0,1,0,0,0,0,2'b00,3'b000,2'b00,0);
    localparam logic [15:0] V_EXEC_SLT = cv(0,0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0);
    localparam logic [15:0] V_EXEC_SUB = cv(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0);
    localparam logic [15:0] V_ALUWB    = cv(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0);
    localparam logic [15:0] V_BR_TAKEN = cv(1,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0);
    localparam logic [15:0] V_BR_NOT   = cv(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0);
    localparam logic [15:0] V_ADDIWB   = cv(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0);
    localparam logic [15:0] V_JUMP     = cv(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0);

    task automatic test_reset();
        sys_rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode    = OP_LW;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        #1;
        total++;
        if (ctrl !== V_RST) begin
            bad++;
            $display("FAIL reset_outputs: ctrl=%b expected=%b", ctrl, V_RST);
        end
        total++;
        if (state_o !== 4'(FETCH)) begin
            bad++;
            $display("FAIL reset_state: state=%0d expected=%0d", state_o, FETCH);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        total++;
        if ({state_o, ctrl} !== {4'(FETCH), V_FWAIT}) begin
            bad++;
            $display("FAIL fetch_wait: state=%0d ctrl=%b expected state=%0d ctrl=%b",
                     state_o, ctrl, FETCH, V_FWAIT);
        end
    endtask

    task automatic test_lw();
        logic [3:0]  es[6];
        logic [15:0] ec[6];
        logic        mr[6];
        es = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH};
        ec = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FWAIT};
        mr = '{1, 1, 1, 1, 1, 0};
        opcode = OP_LW;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            mem_ready = mr[i];
            #1;
            total++;
            if ({state_o, ctrl} !== {es[i], ec[i]}) begin
                bad++;
                $display("FAIL lw step %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b",
                         i, state_o, ctrl, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0]  es[7];
        logic [15:0] ec[7];
        logic        mr[7];
        es = '{FETCH, DECODE, MEMADR, MEMWR, MEMWR, MEMWR, FETCH};
        ec = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_MEMWR, V_MEMWR, V_FWAIT};
        mr = '{1, 1, 1, 0, 0, 1, 0};
        opcode = OP_SW;
        for (int i = 0; i < 7; i++) begin
            @(negedge sys_clk);
            mem_ready = mr[i];
            #1;
            total++;
            if ({state_o, ctrl} !== {es[i], ec[i]}) begin
                bad++;
                $display("FAIL sw_wait step %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b",
                         i, state_o, ctrl, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_beq();
        logic [3:0]  es[7];
        logic [15:0] ec[7];
        logic        mr[7];
        logic        zr[7];
        es = '{FETCH, DECODE, BRANCH, FETCH, DECODE, BRANCH, FETCH};
        ec = '{V_FETCH, V_DECODE, V_BR_TAKEN, V_FETCH, V_DECODE, V_BR_NOT, V_FWAIT};
        mr = '{1, 1, 1, 1, 1, 1, 0};
        zr = '{1, 1, 1, 0, 1, 0, 0};
        opcode = OP_BEQ;
        for (int i = 0; i < 7; i++) begin
            @(negedge sys_clk);
            mem_ready = mr[i];
            zero      = zr[i];
            #1;
            total++;
            if ({state_o, ctrl} !== {es[i], ec[i]}) begin
                bad++;
                $display("FAIL beq step %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b",
                         i, state_o, ctrl, es[i], ec[i]);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_rtype();
        logic [3:0]  es[9];
        logic [15:0] ec[9];
        logic [5:0]  fn[9];
        es = '{FETCH, DECODE, EXECUTE, ALUWB, FETCH, DECODE, EXECUTE, ALUWB, FETCH};
        ec = '{V_FETCH, V_DECODE, V_EXEC_SLT, V_ALUWB, V_FETCH, V_DECODE, V_EXEC_SUB, V_ALUWB, V_FWAIT};
        fn = '{FN_SLT, FN_SLT, FN_SLT, FN_SLT, FN_SUB, FN_SUB, FN_SUB, FN_SUB, FN_SUB};
        opcode = OP_RTYPE;
        for (int i = 0; i < 9; i++) begin
            @(negedge sys_clk);
            mem_ready = (i != 8);
            funct     = fn[i];
            #1;
            total++;
            if ({state_o, ctrl} !== {es[i], ec[i]}) begin
                bad++;
                $display("FAIL rtype step %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b",
                         i, state_o, ctrl, es[i], ec[i]);
            end
        end
    endtask

    // Unsupported funct under R-type, then unsupported opcode.
    task automatic test_illegal();
        logic [3:0]  es[7];
        logic [15:0] ec[7];
        logic [5:0]  op[7];
        es = '{FETCH, DECODE, FETCH, DECODE, FETCH, FETCH, FETCH};
        ec = '{V_FETCH, V_DEC_ILL, V_FETCH, V_DEC_ILL, V_FWAIT, V_FWAIT, V_FWAIT};
        op = '{OP_RTYPE, OP_RTYPE, 6'b111111, 6'b111111, 6'b111111, 6'b111111, 6'b111111};
        funct = 6'b000111;
        for (int i = 0; i < 7; i++) begin
            @(negedge sys_clk);
            mem_ready = (i < 4);
            opcode    = op[i];
            #1;
            total++;
            if ({state_o, ctrl} !== {es[i], ec[i]}) begin
                bad++;
                $display("FAIL illegal step %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b",
                         i, state_o, ctrl, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_addi_jump();
        logic [3:0]  es[9];
        logic [15:0] ec[9];
        logic [5:0]  op[9];
        es = '{FETCH, DECODE, ADDIEX, ADDIWB, FETCH, DECODE, JUMP, FETCH, FETCH};
        ec = '{V_FETCH, V_DECODE, V_MEMADR, V_ADDIWB, V_FETCH, V_DECODE, V_JUMP, V_FWAIT, V_FWAIT};
        op = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_J, OP_J, OP_J, OP_J, OP_J};
        for (int i = 0; i < 9; i++) begin
            @(negedge sys_clk);
            mem_ready = (i < 7);
            opcode    = op[i];
            #1;
            total++;
            if ({state_o, ctrl} !== {es[i], ec[i]}) begin
                bad++;
                $display("FAIL addi_jump step %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b",
                         i, state_o, ctrl, es[i], ec[i]);
            end
        end
    endtask

    // Reset pulse while a store is waiting on memory.
    task automatic test_reset_mid_sw();
        logic [3:0]  es[6];
        logic [15:0] ec[6];
        logic        mr[6];
        logic        rs[6];
        es = '{FETCH, DECODE, MEMADR, MEMWR, MEMWR, FETCH};
        ec = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_RST, V_FWAIT};
        mr = '{1, 1, 1, 0, 0, 0};
        rs = '{1, 1, 1, 1, 0, 1};
        opcode = OP_SW;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            mem_ready = mr[i];
            sys_rst_n = rs[i];
            #1;
            total++;
            if ({state_o, ctrl} !== {es[i], ec[i]}) begin
                bad++;
                $display("FAIL reset_mid_sw step %0d: state=%0d ctrl=%b expected state=%0d ctrl=%b",
                         i, state_o, ctrl, es[i], ec[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_rtype();
        test_illegal();
        test_addi_jump();
        test_reset_mid_sw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
